// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that writes 14-bit words into program memory
// Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 14,
  parameter int MAX_WORDS      = 2048,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       len_h;
  logic [CNT_W-1:0] n_words;
  logic [7:0]       sum;
  logic [5:0]       hi_bits;
  logic [15:0]      len_n;
  logic             len_bad;
  logic [CNT_W-1:0] wc_inc;
  logic             rx_state;
  logic             xfer;
  logic             tmo_hit;

  // Receive states are exactly the states that accept a stream byte.
  assign rx_state   = (state == S_LEN_H) || (state == S_LEN_L) || (state == S_DATA_H) ||
                      (state == S_DATA_L) || (state == S_CHK);
  assign byte_ready = rx_state;
  assign prog_we    = (state == S_WRITE);
  assign xfer       = byte_valid && rx_state;

  assign len_n   = {len_h, byte_in};
  assign len_bad = (len_n == 16'd0) || (17'(len_n) > 17'(MAX_WORDS));
  assign wc_inc  = word_count + CNT_W'(1);

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = rx_state && !byte_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter: restarts on every accepted byte and outside receive states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (!rx_state || byte_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: frame parsing, length/HI/checksum validation.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LEN_H;
      S_LEN_H:  if (byte_valid) state_next = S_LEN_L;
      S_LEN_L:  if (byte_valid) state_next = len_bad ? S_ERR : S_DATA_H;
      S_DATA_H: if (byte_valid) state_next = (byte_in[7:6] != 2'b00) ? S_ERR : S_DATA_L;
      S_DATA_L: if (byte_valid) state_next = S_WRITE;
      S_WRITE:  state_next = (wc_inc == n_words) ? S_CHK : S_DATA_H;
      S_CHK:    if (byte_valid) state_next = (byte_in == sum) ? S_DONE : S_ERR;
      S_DONE:   state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (tmo_hit) state_next = S_ERR;
  end

  // Datapath: length capture, running checksum, word assembly, address/count and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_h      <= '0;
      n_words    <= '0;
      sum        <= '0;
      hi_bits    <= '0;
      prog_addr  <= '0;
      prog_data  <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            prog_addr  <= '0;
            sum        <= '0;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
          end
        end
        S_LEN_H: begin
          if (xfer) begin
            len_h <= byte_in;
            sum   <= sum + byte_in;
          end
        end
        S_LEN_L: begin
          if (xfer) begin
            // Only meaningful when the length is legal, which always fits CNT_W bits.
            n_words <= len_n[CNT_W-1:0];
            sum     <= sum + byte_in;
          end
        end
        S_DATA_H: begin
          if (xfer) begin
            hi_bits <= byte_in[5:0];
            sum     <= sum + byte_in;
          end
        end
        S_DATA_L: begin
          if (xfer) begin
            prog_data <= {hi_bits, byte_in};
            sum       <= sum + byte_in;
          end
        end
        S_WRITE: begin
          prog_addr  <= prog_addr + ADDR_W'(1);
          word_count <= wc_inc;
        end
        S_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        S_ERR: begin
          error    <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 14;
  localparam int MAX_WORDS = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  program_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0]  frame[$];
  int          exp_addr[$];
  int          exp_data[$];
  int          cap_addr[$];
  int          cap_data[$];
  int          exp_done;
  int          exp_err;

  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      cap_addr.push_back(int'(prog_addr));
      cap_data.push_back(int'(prog_data));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int c;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    c = 0;
    while (byte_ready !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) check("byte_accept_timeout", 0, 1);
    else @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  // Reference model: random words -> frame bytes, expected writes and outcome.
  // mode 0 = good frame, 1 = corrupted checksum, 2 = illegal HI byte in some word.
  task automatic build(input int n, input int mode);
    int s, bad_k, w, hi, lo, chk;
    frame.delete(); exp_addr.delete(); exp_data.delete();
    frame.push_back(8'((n >> 8) & 255));
    frame.push_back(8'(n & 255));
    s = ((n >> 8) & 255) + (n & 255);
    bad_k = (mode == 2) ? int'($urandom_range(0, n - 1)) : -1;
    for (int i = 0; i < n; i++) begin
      w  = int'($urandom & 32'h3FFF);
      hi = w / 256;
      lo = w % 256;
      if (i == bad_k) begin
        hi = hi + 64 * int'($urandom_range(1, 3));
        frame.push_back(8'(hi));
        break;
      end
      frame.push_back(8'(hi));
      frame.push_back(8'(lo));
      exp_addr.push_back(i % (1 << ADDR_W));
      exp_data.push_back(w);
      s = s + hi + lo;
    end
    if (mode != 2) begin
      chk = s % 256;
      if (mode == 1) chk = chk ^ int'($urandom_range(1, 255));
      frame.push_back(8'(chk));
    end
    exp_done = (mode == 0) ? 1 : 0;
    exp_err  = (mode == 0) ? 0 : 1;
  endtask

  task automatic run_frame(input string tag, input int max_gap, input int mid_start_idx);
    int nw;
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    for (int i = 0; i < frame.size(); i++) begin
      if (i == mid_start_idx) pulse_start();
      send_byte(frame[i], int'($urandom_range(0, max_gap)));
    end
    wait_idle();
    check({tag, ":n_writes"}, cap_addr.size(), exp_addr.size());
    nw = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < nw; i++) begin
      check({tag, ":addr"}, cap_addr[i], exp_addr[i]);
      check({tag, ":data"}, cap_data[i], exp_data[i]);
    end
    check({tag, ":done"}, int'(done), exp_done);
    check({tag, ":error"}, int'(error), exp_err);
    check({tag, ":word_count"}, int'(word_count), exp_addr.size());
    check({tag, ":cpu_hold"}, int'(cpu_hold), 0);
    check({tag, ":byte_ready"}, int'(byte_ready), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    @(negedge clk);
    check("rst:byte_ready", int'(byte_ready), 0);
    check("rst:prog_we", int'(prog_we), 0);
    check("rst:prog_addr", int'(prog_addr), 0);
    check("rst:prog_data", int'(prog_data), 0);
    check("rst:cpu_hold", int'(cpu_hold), 0);
    check("rst:busy", int'(busy), 0);
    check("rst:done", int'(done), 0);
    check("rst:error", int'(error), 0);
    check("rst:word_count", int'(word_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed example frame, good checksum.
    frame = '{8'h00, 8'h02, 8'h01, 8'hA5, 8'h30, 8'h07, 8'hDF};
    exp_addr = '{0, 1}; exp_data = '{32'h01A5, 32'h3007};
    exp_done = 1; exp_err = 0;
    pulse_start();
    check("start:busy", int'(busy), 1);
    check("start:cpu_hold", int'(cpu_hold), 1);
    frame.delete();
    frame = '{8'h00, 8'h02, 8'h01, 8'hA5, 8'h30, 8'h07, 8'hDF};
    // Already started above; feed bytes without a second start.
    cap_addr.delete(); cap_data.delete();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 0);
    wait_idle();
    check("ex:n_writes", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      check("ex:addr0", cap_addr[0], 0); check("ex:data0", cap_data[0], 32'h01A5);
      check("ex:addr1", cap_addr[1], 1); check("ex:data1", cap_data[1], 32'h3007);
    end
    check("ex:done", int'(done), 1);
    check("ex:error", int'(error), 0);
    check("ex:word_count", int'(word_count), 2);
    check("ex:cpu_hold", int'(cpu_hold), 0);

    // Same frame with wrong checksum.
    frame = '{8'h00, 8'h02, 8'h01, 8'hA5, 8'h30, 8'h07, 8'hDE};
    exp_addr = '{0, 1}; exp_data = '{32'h01A5, 32'h3007};
    exp_done = 0; exp_err = 1;
    run_frame("badchk", 0, -1);

    // Zero length, oversize length, bad HI bits.
    frame = '{8'h00, 8'h00}; exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 1;
    run_frame("len0", 0, -1);
    frame = '{8'h08, 8'h01};
    run_frame("len2049", 0, -1);
    frame = '{8'h00, 8'h01, 8'h41};
    run_frame("badhi", 0, -1);

    // Start pulse mid-load is ignored.
    build(5, 0);
    run_frame("midstart", 2, 6);

    // Reset while the first write strobe is high.
    frame = '{8'h00, 8'h02, 8'h01, 8'hA5};
    pulse_start();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 0);
    check("rstmid:we_before", int'(prog_we), 1);
    #2 reset = 1'b1;
    #1;
    check("rstmid:prog_we", int'(prog_we), 0);
    check("rstmid:busy", int'(busy), 0);
    check("rstmid:cpu_hold", int'(cpu_hold), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    build(3, 0);
    run_frame("after_rst", 1, -1);

    // Random frames against the model.
    for (int t = 0; t < 20; t++) begin
      build(int'($urandom_range(1, 24)), int'($urandom_range(0, 2)));
      run_frame("rand", 3, -1);
    end

    // Largest legal load: address wraps back to 0 after the last word.
    build(MAX_WORDS, 0);
    run_frame("maxlen", 0, -1);
    check("maxlen:addr_wrap", int'(prog_addr), 0);

`ifndef LOADER_TIMEOUT_EN
    // Without the timeout, a stalled stream keeps the loader busy.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    repeat (40) @(negedge clk);
    check("stall:busy", int'(busy), 1);
    check("stall:cpu_hold", int'(cpu_hold), 1);
    check("stall:error", int'(error), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
